wb_regwrite: RTL

Writeback stage: the write-side counterpart of the operand-read stage. Accepts completed results from the memory stage, decides whether the architectural register write actually happens (conditional-on-carry/zero instructions), maintains the carry and zero flag registers, and drives the register-file write port (`rf_write_en`, `rf_write_address`, `rf_write_data`). Also sequences Load-Multiple (LM) instructions as one register write per cycle, stalling upstream while it does so. It optionally exposes a same-cycle forwarding path to operand read.

---
 rtl/wb_regwrite.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_regwrite.sv
// Writeback stage: conditional register-file writes, C/Z flag registers and Load-Multiple sequencing.
// Optional same-cycle forwarding path enabled by defining WB_FORWARD_EN.
module wb_regwrite (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_wr,
    input  logic [2:0]  in_dest,
    input  logic [15:0] in_data,
    input  logic        in_flag_we,
    input  logic        in_c,
    input  logic        in_z,
    input  logic        checkr_c,
    input  logic        checkr_z,
    input  logic        in_lm,
    input  logic [7:0]  in_lm_mask,
    input  logic [15:0] in_lm_base,
    input  logic [15:0] mem_rd_data,
    output logic        mem_rd_en,
    output logic [15:0] mem_rd_addr,
    output logic        rf_write_en,
    output logic [2:0]  rf_write_address,
    output logic [15:0] rf_write_data,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        stall,
    output logic        fwd_en,
    output logic [2:0]  fwd_addr,
    output logic [15:0] fwd_data
);

    typedef enum logic {S_IDLE, S_LM_RUN} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_mask, w_mask_next;
    logic [15:0] r_ptr, w_ptr_next;
    logic        r_c, r_z, w_c_next, w_z_next;
    logic        r_wr_en;
    logic [2:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        w_we;
    logic [2:0]  w_waddr;
    logic [15:0] w_wdata;
    logic [2:0]  w_lm_idx;
    logic [7:0]  w_lm_onehot;
    logic        w_cond_ok;
    logic        w_lm_run;

    assign w_lm_run    = (r_state == S_LM_RUN);
    assign w_cond_ok   = (!checkr_c | r_c) & (!checkr_z | r_z);
    assign w_lm_onehot = r_mask & (~r_mask + 8'd1);

    // Scan from the top so the last hit is the lowest set bit.
    always_comb begin
        w_lm_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (r_mask[k]) w_lm_idx = 3'(k);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_ptr_next   = r_ptr;
        w_c_next     = r_c;
        w_z_next     = r_z;
        w_we         = 1'b0;
        w_waddr      = 3'd0;
        w_wdata      = 16'd0;
        // Under reset nothing is scheduled, so forwarding stays quiet too.
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_lm) begin
                            if (in_lm_mask != 8'd0) begin
                                w_mask_next  = in_lm_mask;
                                w_ptr_next   = in_lm_base;
                                w_state_next = S_LM_RUN;
                            end
                        end else begin
                            if (in_wr && w_cond_ok) begin
                                w_we    = 1'b1;
                                w_waddr = in_dest;
                                w_wdata = in_data;
                            end
                            if (in_flag_we && w_cond_ok) begin
                                w_c_next = in_c;
                                w_z_next = in_z;
                            end
                        end
                    end
                end
                S_LM_RUN: begin
                    w_we        = 1'b1;
                    w_waddr     = w_lm_idx;
                    w_wdata     = mem_rd_data;
                    w_mask_next = r_mask & ~w_lm_onehot;
                    w_ptr_next  = r_ptr + 16'd1;
                    if (w_mask_next == 8'd0) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mask    <= 8'd0;
            r_ptr     <= 16'd0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 3'd0;
            r_wr_data <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_mask    <= w_mask_next;
            r_ptr     <= w_ptr_next;
            r_c       <= w_c_next;
            r_z       <= w_z_next;
            r_wr_en   <= w_we;
            r_wr_addr <= w_waddr;
            r_wr_data <= w_wdata;
        end
    end

    assign rf_write_en      = r_wr_en;
    assign rf_write_address = r_wr_addr;
    assign rf_write_data    = r_wr_data;
    assign carry_flag       = r_c;
    assign zero_flag        = r_z;
    assign stall            = w_lm_run;
    assign mem_rd_en        = w_lm_run;
    assign mem_rd_addr      = w_lm_run ? r_ptr : 16'd0;

`ifdef WB_FORWARD_EN
    assign fwd_en   = w_we;
    assign fwd_addr = w_waddr;
    assign fwd_data = w_wdata;
`else
    assign fwd_en   = 1'b0;
    assign fwd_addr = 3'd0;
    assign fwd_data = 16'd0;
`endif

endmodule
